// File: rtl/dm_bus_arbiter_if.sv
// Data-memory port bundle: CPU and DMA requesters plus the memory handshake.
// The arbiter takes the master view; requesters and memory take the slave view.
interface dm_bus_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_byteen;
    logic [31:0] cpu_wdata;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [3:0]  dma_byteen;
    logic [31:0] dma_wdata;
    logic        dma_done;
    logic [31:0] dma_rdata;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_byteen, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_byteen, dma_wdata,
        input  mem_ack, mem_rdata,
        output cpu_done, cpu_rdata, cpu_stall,
        output dma_done, dma_rdata, bus_err,
        output mem_req, mem_we, mem_addr, mem_byteen, mem_wdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_byteen, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_byteen, dma_wdata,
        output mem_ack, mem_rdata,
        input  cpu_done, cpu_rdata, cpu_stall,
        input  dma_done, dma_rdata, bus_err,
        input  mem_req, mem_we, mem_addr, mem_byteen, mem_wdata
    );
endinterface

// File: rtl/dm_bus_arbiter.sv
// Data-memory port arbiter between the CPU M-stage and the DMA/debug master.
// One latched transaction at a time, round-robin on ties, with ack timeout.
module dm_bus_arbiter #(
    parameter int TIMEOUT = 64
) (
    input logic              clk,
    input logic              reset,
    dm_bus_arbiter_if.master bus
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic { S_IDLE, S_WAIT } state_e;
    typedef enum logic { OWN_CPU, OWN_DMA } owner_e;

    state_e        state_q, state_d;
    owner_e        last_grant_q, last_grant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [3:0]    mem_byteen_q, mem_byteen_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          cpu_done_q, cpu_done_d;
    logic          dma_done_q, dma_done_d;
    logic          bus_err_q, bus_err_d;
    logic [31:0]   cpu_rdata_q, cpu_rdata_d;
    logic [31:0]   dma_rdata_q, dma_rdata_d;
    logic          pick_cpu, pick_dma, done_cycle;

    // Ties go to whoever was not served last.
    assign pick_cpu   = bus.cpu_req & (~bus.dma_req | (last_grant_q == OWN_DMA));
    assign pick_dma   = bus.dma_req & (~bus.cpu_req | (last_grant_q == OWN_CPU));
    assign done_cycle = cpu_done_q | dma_done_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_byteen_d = mem_byteen_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_done_d   = 1'b0;
        dma_done_d   = 1'b0;
        bus_err_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                mem_req_d = 1'b0;
                // The owner still holds req during its done cycle; skip it.
                if (!done_cycle) begin
                    unique case (1'b1)
                        pick_cpu: begin
                            state_d      = S_WAIT;
                            last_grant_d = OWN_CPU;
                            cnt_d        = '0;
                            mem_req_d    = 1'b1;
                            mem_we_d     = bus.cpu_we;
                            mem_addr_d   = bus.cpu_addr & 32'hFFFF_FFFC;
                            mem_byteen_d = bus.cpu_we ? bus.cpu_byteen : 4'b0000;
                            mem_wdata_d  = bus.cpu_wdata;
                        end
                        pick_dma: begin
                            state_d      = S_WAIT;
                            last_grant_d = OWN_DMA;
                            cnt_d        = '0;
                            mem_req_d    = 1'b1;
                            mem_we_d     = bus.dma_we;
                            mem_addr_d   = bus.dma_addr & 32'hFFFF_FFFC;
                            mem_byteen_d = bus.dma_we ? bus.dma_byteen : 4'b0000;
                            mem_wdata_d  = bus.dma_wdata;
                        end
                        default: ;
                    endcase
                end
            end
            S_WAIT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                if (bus.mem_ack) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    if (last_grant_q == OWN_CPU) begin
                        cpu_done_d  = 1'b1;
                        cpu_rdata_d = bus.mem_rdata;
                    end else begin
                        dma_done_d  = 1'b1;
                        dma_rdata_d = bus.mem_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (last_grant_q == OWN_CPU) begin
                        cpu_done_d  = 1'b1;
                        cpu_rdata_d = 32'h0;
                    end else begin
                        dma_done_d  = 1'b1;
                        dma_rdata_d = 32'h0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= OWN_DMA;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_byteen_q <= 4'b0000;
            mem_wdata_q  <= 32'h0;
            cpu_done_q   <= 1'b0;
            dma_done_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            cpu_rdata_q  <= 32'h0;
            dma_rdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_byteen_q <= mem_byteen_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_done_q   <= cpu_done_d;
            dma_done_q   <= dma_done_d;
            bus_err_q    <= bus_err_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_byteen = mem_byteen_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_done   = cpu_done_q;
    assign bus.dma_done   = dma_done_q;
    assign bus.bus_err    = bus_err_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dma_rdata  = dma_rdata_q;
    assign bus.cpu_stall  = bus.cpu_req & ~cpu_done_q;
endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Bench for dm_bus_arbiter: memory responder, done-pulse scoreboard and
// directed scenarios for latching, arbitration, timeout and reset.
module tb_dm_bus_arbiter;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dm_bus_arbiter_if bus ();

    dm_bus_arbiter #(.TIMEOUT(64)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        dma;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks   = 0;
    int          failures = 0;
    int          ack_lat  = 0;
    int          req_cyc  = 0;
    logic        use_fixed  = 1'b0;
    logic [31:0] fixed_word = 32'h0;
    logic        stray      = 1'b0;
    logic [31:0] obs_rd;

    // Memory model: acks after ack_lat cycles of mem_req (negative = never).
    always @(negedge clk) begin
        if (stray) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'h5555_5555;
            stray         = 1'b0;
        end else if (bus.mem_req && ack_lat >= 0 && req_cyc == ack_lat) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = use_fixed ? fixed_word : (32'hC0DE_0000 ^ bus.mem_addr);
            req_cyc       = req_cyc + 1;
        end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'hDEAD_BEEF;
            req_cyc       = bus.mem_req ? req_cyc + 1 : 0;
        end
    end

    // Scoreboard: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && (bus.cpu_done || bus.dma_done)) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_done: cpu_done=%b dma_done=%b, expected no done",
                         bus.cpu_done, bus.dma_done);
            end else begin
                e      = sb.pop_front();
                obs_rd = e.dma ? bus.dma_rdata : bus.cpu_rdata;
                if ({bus.dma_done, bus.cpu_done} !== {e.dma, ~e.dma} ||
                    obs_rd !== e.rdata || bus.bus_err !== e.err) begin
                    failures++;
                    $display("FAIL sb_done: got dma/cpu=%b%b rdata=%h err=%b, want dma=%b rdata=%h err=%b",
                             bus.dma_done, bus.cpu_done, obs_rd, bus.bus_err,
                             e.dma, e.rdata, e.err);
                end
            end
        end
    end

    task automatic drive(input logic dma, input logic req, input logic we,
                         input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd);
        if (dma) begin
            bus.dma_req = req; bus.dma_we = we; bus.dma_addr = a;
            bus.dma_byteen = be; bus.dma_wdata = wd;
        end else begin
            bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a;
            bus.cpu_byteen = be; bus.cpu_wdata = wd;
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        return use_fixed ? fixed_word : (32'hC0DE_0000 ^ (a & 32'hFFFF_FFFC));
    endfunction

    task automatic apply_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        sb.delete();
        ack_lat = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // One isolated transaction; returns cycles mem_req was high.
    task automatic do_txn(input logic dma, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd,
                          input int lat, input int exp_n, input int drop_after,
                          input string name, output int req_hi);
        logic        err;
        logic [31:0] exp_rd;
        logic        seen;
        int          n;
        ack_lat = lat;
        err     = (lat < 0) || (lat > 63);
        exp_rd  = err ? 32'h0 : model_word(addr);
        @(negedge clk);
        drive(dma, 1'b1, we, addr, be, wd);
        sb.push_back('{dma, exp_rd, err});
        n = 0; seen = 1'b0; req_hi = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (bus.mem_req) req_hi++;
            if (bus.mem_req && !seen) begin
                seen = 1'b1;
                checks++;
                if ({bus.mem_we, bus.mem_addr, bus.mem_byteen, bus.mem_wdata} !==
                    {we, addr & 32'hFFFF_FFFC, we ? be : 4'b0000, wd} || n !== 1) begin
                    failures++;
                    $display("FAIL %s_fields: got we=%b addr=%h be=%b wd=%h at cycle %0d, want we=%b addr=%h be=%b wd=%h at cycle 1",
                             name, bus.mem_we, bus.mem_addr, bus.mem_byteen, bus.mem_wdata, n,
                             we, addr & 32'hFFFF_FFFC, we ? be : 4'b0000, wd);
                end
            end
            if (drop_after > 0 && n == drop_after) drive(dma, 1'b0, we, addr, be, wd);
            if (dma ? bus.dma_done : bus.cpu_done) break;
        end
        checks++;
        if (n !== exp_n) begin
            failures++;
            $display("FAIL %s_latency: done after %0d cycles, want %0d", name, n, exp_n);
        end
        checks++;
        if (bus.cpu_stall !== 1'b0) begin
            failures++;
            $display("FAIL %s_stall: cpu_stall=%b in done cycle, want 0", name, bus.cpu_stall);
        end
        drive(dma, 1'b0, we, addr, be, wd);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_byteen, bus.mem_wdata,
             bus.cpu_done, bus.dma_done, bus.bus_err, bus.cpu_rdata, bus.dma_rdata,
             bus.cpu_stall} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: mem_req=%b addr=%h done=%b%b err=%b rd=%h/%h, want all 0",
                     bus.mem_req, bus.mem_addr, bus.cpu_done, bus.dma_done, bus.bus_err,
                     bus.cpu_rdata, bus.dma_rdata);
        end
        reset = 1'b1;
    endtask

    task automatic test_store();
        int hi;
        do_txn(1'b0, 1'b1, 32'h10, 4'b1111, 32'h1234_5678, 2, 4, 0, "cpu_sw", hi);
        @(negedge clk);
        checks++;
        if (bus.cpu_stall !== 1'b0 || bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL cpu_sw_after: stall=%b mem_req=%b, want 0 0", bus.cpu_stall, bus.mem_req);
        end
    endtask

    task automatic test_load();
        int hi;
        use_fixed  = 1'b1;
        fixed_word = 32'hAABB_CCDD;
        do_txn(1'b0, 1'b0, 32'h13, 4'b0010, 32'h0, 0, 2, 0, "cpu_lb", hi);
        use_fixed = 1'b0;
    endtask

    task automatic test_rdata_hold();
        int hi;
        do_txn(1'b1, 1'b1, 32'h42, 4'b1100, 32'hBEEF_0000, 1, 3, 0, "dma_sh", hi);
        @(negedge clk);
        checks++;
        if (bus.cpu_rdata !== 32'hAABB_CCDD) begin
            failures++;
            $display("FAIL rdata_hold: cpu_rdata=%h, want aabbccdd", bus.cpu_rdata);
        end
    endtask

    task automatic test_stray_ack();
        @(posedge clk);
        stray = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0 || bus.cpu_rdata !== 32'hAABB_CCDD ||
            bus.dma_rdata !== (32'hC0DE_0000 ^ 32'h40)) begin
            failures++;
            $display("FAIL stray_ack: mem_req=%b cpu_rdata=%h dma_rdata=%h, want 0 aabbccdd c0de0040",
                     bus.mem_req, bus.cpu_rdata, bus.dma_rdata);
        end
    endtask

    task automatic test_arbitration();
        int    dones;
        int    n;
        logic  first;
        apply_reset();
        ack_lat = 0;
        drive(1'b0, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h200, 4'h0, 32'h0);
        for (int i = 0; i < 4; i++)
            sb.push_back('{(i % 2) == 1, model_word((i % 2) == 1 ? 32'h200 : 32'h100), 1'b0});
        dones = 0; n = 0; first = 1'b1;
        while (dones < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.mem_req && first) begin
                first = 1'b0;
                checks++;
                if (bus.mem_addr !== 32'h100) begin
                    failures++;
                    $display("FAIL arb_first: mem_addr=%h, want 00000100 (CPU)", bus.mem_addr);
                end
            end
            if (bus.cpu_done || bus.dma_done) dones++;
        end
        drive(1'b0, 1'b0, 1'b0, 32'h100, 4'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h200, 4'h0, 32'h0);
        checks++;
        if (dones !== 4) begin
            failures++;
            $display("FAIL arb_alternate: %0d dones in budget, want 4", dones);
        end
    endtask

    task automatic test_timeout();
        int hi;
        do_txn(1'b0, 1'b0, 32'h80, 4'h0, 32'h0, -1, 65, 0, "timeout", hi);
        checks++;
        if (hi !== 64) begin
            failures++;
            $display("FAIL timeout_req_len: mem_req high %0d cycles, want 64", hi);
        end
        @(negedge clk);
        checks++;
        if (bus.bus_err !== 1'b0 || bus.cpu_done !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse: err=%b done=%b one cycle later, want 0 0",
                     bus.bus_err, bus.cpu_done);
        end
    endtask

    task automatic test_ack_on_timeout();
        int hi;
        do_txn(1'b1, 1'b0, 32'h84, 4'h0, 32'h0, 63, 65, 0, "ack_at_timeout", hi);
    endtask

    task automatic test_drop_in_wait();
        int hi;
        do_txn(1'b0, 1'b1, 32'h24, 4'b0001, 32'h0000_00AB, 4, 6, 1, "drop_in_wait", hi);
    endtask

    task automatic test_reset_mid_wait();
        int n;
        ack_lat = -1;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h300, 4'h0, 32'h0);
        repeat (3) @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 32'h404, 4'b0011, 32'h0000_1234);
        checks++;
        if (bus.mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre: mem_req=%b, want 1", bus.mem_req);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_async: mem_req=%b, want 0", bus.mem_req);
        end
        sb.delete();
        drive(1'b0, 1'b0, 1'b0, 32'h300, 4'h0, 32'h0);
        @(negedge clk);
        reset   = 1'b1;
        ack_lat = 0;
        sb.push_back('{1'b1, model_word(32'h404), 1'b0});
        n = 0;
        while (!bus.dma_done && n < 50) begin
            @(negedge clk);
            n++;
            if (bus.mem_req) begin
                checks++;
                if (bus.mem_addr !== 32'h404 || bus.mem_byteen !== 4'b0011) begin
                    failures++;
                    $display("FAIL rst_mid_dma: addr=%h be=%b, want 00000404 0011",
                             bus.mem_addr, bus.mem_byteen);
                end
            end
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL rst_mid_done: no dma_done in 50 cycles, want done");
        end
    endtask

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        test_reset();
        test_store();
        test_load();
        test_rdata_hold();
        test_stray_ack();
        test_arbitration();
        test_timeout();
        test_ack_on_timeout();
        test_drop_in_wait();
        test_reset_mid_wait();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d expectations pending, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
